rgb565_to_hsv: RTL and testbench

Pipelined colour-space converter that sits directly upstream of the colour-detection stage on the 125 MHz processing clock. It accepts RGB565 pixels with their frame-buffer write address and a valid strobe, as produced alongside the memory-interface write path. It emits 8-bit hue/saturation/value plus the untouched pixel and address after a fixed latency. It accepts one pixel per cycle with no back-pressure, so the colour classifier compares HSV thresholds instead of raw RGB.

---
 rtl/rgb565_to_hsv.sv | 192 +++++++++++++++++++
 tb/tb_rgb565_to_hsv.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rgb565_to_hsv.sv
// RGB565 to 8-bit HSV converter: twelve-stage pipeline with one pixel per cycle and no back-pressure.
// Hue is in 2-degree units (0..179). Saturation and hue quotients come from restoring dividers, one quotient bit per stage.
module rgb565_to_hsv #(
  parameter int ADDR_WIDTH = 18,
  parameter int LATENCY    = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [15:0]           i_data,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_valid,
  output logic [15:0]           o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [7:0]            o_hue,
  output logic [7:0]            o_sat,
  output logic [7:0]            o_val
);

  localparam int PIPE_STAGES = 12;
  localparam int DIV_STEPS   = 8;
  localparam int LAST_DATA   = PIPE_STAGES - 1;

  generate
    if (LATENCY != PIPE_STAGES) begin : g_latency_check
      $error("rgb565_to_hsv: LATENCY must equal the implemented depth of 12");
    end
  endgenerate

  typedef enum logic [1:0] {SEL_R, SEL_G, SEL_B} sel_e;

  // A divider step holds the partial remainder, the numerator bits still to
  // be consumed, and the quotient collected so far.
  typedef struct packed {
    logic [7:0] rem;
    logic [7:0] lo;
    logic [7:0] q;
  } div_t;

  function automatic div_t div_step(input div_t cur, input logic [7:0] divisor);
    logic [8:0] trial;
    logic [8:0] diff;
    div_t       nxt;
    trial  = {cur.rem, cur.lo[7]};
    diff   = trial - {1'b0, divisor};
    nxt.lo = {cur.lo[6:0], 1'b0};
    if (trial >= {1'b0, divisor}) begin
      nxt.rem = diff[7:0];
      nxt.q   = {cur.q[6:0], 1'b1};
    end else begin
      nxt.rem = trial[7:0];
      nxt.q   = {cur.q[6:0], 1'b0};
    end
    return nxt;
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] px);
    return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
  endfunction

  // Valid chain: bit 0 is stage 1 and the top bit is the output register.
  logic [PIPE_STAGES-1:0] vld;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) vld <= '0;
    else                  vld <= {vld[PIPE_STAGES-2:0], i_valid};
  end

  assign o_valid = vld[PIPE_STAGES-1];

  // NOTE: The pixel/address shift chain has no reset. Only the valid chain decides whether its contents are used.
  logic [15:0]           data_q [1:LAST_DATA];
  logic [ADDR_WIDTH-1:0] addr_q [1:LAST_DATA];

  always_ff @(posedge i_clk) begin
    data_q[1] <= i_data;
    addr_q[1] <= i_addr;
    for (int k = 2; k <= LAST_DATA; k++) begin
      data_q[k] <= data_q[k-1];
      addr_q[k] <= addr_q[k-1];
    end
  end

  // Stage 2: max/min/delta and the max channel. Ties are resolved as R > G > B.
  logic [7:0] r1, g1, b1, mx1, mn1;
  sel_e       sel1;
  logic [7:0] s2_max, s2_delta;
  sel_e       s2_sel;

  assign {r1, g1, b1} = expand(data_q[1]);

  always_comb begin
    sel1 = SEL_R;
    mx1  = r1;
    if (!(r1 >= g1 && r1 >= b1)) begin
      if (g1 >= b1) begin sel1 = SEL_G; mx1 = g1; end
      else          begin sel1 = SEL_B; mx1 = b1; end
    end
    mn1 = r1;
    if (g1 < mn1) mn1 = g1;
    if (b1 < mn1) mn1 = b1;
  end

  always_ff @(posedge i_clk) begin
    s2_max   <= mx1;
    s2_delta <= mx1 - mn1;
    s2_sel   <= sel1;
  end

  // Stage 3: numerators and hue sign. A zero divisor is replaced with 1. The numerator is 0 in that case, so the quotient is 0.
  logic [7:0]  r2, g2, b2, mag2;
  logic        neg2;
  logic [15:0] sat_num, hue_num;

  assign {r2, g2, b2} = expand(data_q[2]);

  always_comb begin
    neg2 = 1'b0;
    mag2 = '0;
    unique case (s2_sel)
      SEL_G:   begin neg2 = (b2 < r2); mag2 = neg2 ? r2 - b2 : b2 - r2; end
      SEL_B:   begin neg2 = (r2 < g2); mag2 = neg2 ? g2 - r2 : r2 - g2; end
      default: begin neg2 = (g2 < b2); mag2 = neg2 ? b2 - g2 : g2 - b2; end
    endcase
    sat_num = {s2_delta, 8'h00} - {8'h00, s2_delta};
    hue_num = 16'(mag2) * 16'd30;
  end

  div_t       sat_d   [0:DIV_STEPS];
  div_t       hue_d   [0:DIV_STEPS];
  logic [7:0] sat_div [0:DIV_STEPS];
  logic [7:0] hue_div [0:DIV_STEPS];
  sel_e       sel_q   [0:DIV_STEPS];
  logic       neg_q   [0:DIV_STEPS];
  logic [7:0] val_q   [0:DIV_STEPS];

  always_ff @(posedge i_clk) begin
    sat_d[0]   <= {sat_num, 8'h00};
    hue_d[0]   <= {hue_num, 8'h00};
    sat_div[0] <= (s2_max == 8'd0)   ? 8'd1 : s2_max;
    hue_div[0] <= (s2_delta == 8'd0) ? 8'd1 : s2_delta;
    sel_q[0]   <= s2_sel;
    neg_q[0]   <= neg2;
    val_q[0]   <= s2_max;
  end

  // Stages 4-11: one quotient bit per stage in each divider.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < DIV_STEPS; k++) begin
      sat_d[k+1]   <= div_step(sat_d[k], sat_div[k]);
      hue_d[k+1]   <= div_step(hue_d[k], hue_div[k]);
      sat_div[k+1] <= sat_div[k];
      hue_div[k+1] <= hue_div[k];
      sel_q[k+1]   <= sel_q[k];
      neg_q[k+1]   <= neg_q[k];
      val_q[k+1]   <= val_q[k];
    end
  end

  // Stage 12: sector offset, sign and wrap. Only the R sector can reach 180, because q is at most 30.
  logic [7:0] hq, hue_raw, hue_fin;

  assign hq = hue_d[DIV_STEPS].q;

  always_comb begin
    hue_raw = hq;
    unique case (sel_q[DIV_STEPS])
      SEL_G:   hue_raw = neg_q[DIV_STEPS] ? 8'd60  - hq : 8'd60  + hq;
      SEL_B:   hue_raw = neg_q[DIV_STEPS] ? 8'd120 - hq : 8'd120 + hq;
      default: hue_raw = neg_q[DIV_STEPS] ? 8'd180 - hq : hq;
    endcase
    hue_fin = (hue_raw == 8'd180) ? 8'd0 : hue_raw;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hue  <= '0;
      o_sat  <= '0;
      o_val  <= '0;
      o_data <= '0;
      o_addr <= '0;
    end else if (vld[PIPE_STAGES-2] && !i_flush) begin
      o_hue  <= hue_fin;
      o_sat  <= sat_d[DIV_STEPS].q;
      o_val  <= val_q[DIV_STEPS];
      o_data <= data_q[LAST_DATA];
      o_addr <= addr_q[LAST_DATA];
    end
  end

endmodule

// File: tb/tb_rgb565_to_hsv.sv
// Randomised and directed bench for rgb565_to_hsv. A scoreboard holds the expected output cycle and fields.
// Expected values come from directed constants or from a plain-arithmetic HSV model.
module tb_rgb565_to_hsv;

  localparam int AW  = 18;
  localparam int LAT = 12;

  logic          i_clk = 1'b0;
  logic          i_rst, i_flush, i_valid;
  logic [15:0]   i_data;
  logic [AW-1:0] i_addr;
  logic          o_valid;
  logic [15:0]   o_data;
  logic [AW-1:0] o_addr;
  logic [7:0]    o_hue, o_sat, o_val;

  rgb565_to_hsv #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
    .i_data(i_data), .i_addr(i_addr),
    .o_valid(o_valid), .o_data(o_data), .o_addr(o_addr),
    .o_hue(o_hue), .o_sat(o_sat), .o_val(o_val)
  );

  always #4 i_clk = ~i_clk;

  typedef struct {
    int            tag;
    logic [15:0]   d;
    logic [AW-1:0] a;
    logic [7:0]    h, s, v;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, last_e;
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;
  int   n_push = 0, n_drop = 0, n_out = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: direct integer arithmetic on the 8-bit channels.
  function automatic logic [23:0] hsv_ref(input logic [15:0] px);
    int r, g, b, mx, mn, d, h, s, q;
    r = int'({px[15:11], px[15:13]});
    g = int'({px[10:5], px[10:9]});
    b = int'({px[4:0], px[4:2]});
    mx = (r > g) ? r : g;  mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g;  mn = (b < mn) ? b : mn;
    d  = mx - mn;
    s  = (mx == 0) ? 0 : (d * 255) / mx;
    if (d == 0) h = 0;
    else if (r == mx) begin
      q = 30 * ((g >= b) ? g - b : b - g) / d;
      h = (g >= b) ? q : 180 - q;
    end else if (g == mx) begin
      q = 30 * ((b >= r) ? b - r : r - b) / d;
      h = (b >= r) ? 60 + q : 60 - q;
    end else begin
      q = 30 * ((r >= g) ? r - g : g - r) / d;
      h = (r >= g) ? 120 + q : 120 - q;
    end
    if (h == 180) h = 0;
    return {8'(h), 8'(s), 8'(mx)};
  endfunction

  always @(negedge i_clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("latency", cyc, mon_e.tag);
        check("data", o_data, mon_e.d);
        check("addr", o_addr, mon_e.a);
        check("hue", o_hue, mon_e.h);
        check("sat", o_sat, mon_e.s);
        check("val", o_val, mon_e.v);
        last_e = mon_e;
        n_out++;
      end
    end
    if (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
      check("missing_out", cyc, exp_q[0].tag);
      void'(exp_q.pop_front());
    end
  end

  // Each call occupies one input cycle. Flush or reset discards every pixel that has not yet reached the output.
  task automatic put(input logic v, input logic [15:0] d, input logic [AW-1:0] a,
                     input logic fl, input logic rs, input logic [23:0] hsv);
    i_valid = v; i_data = d; i_addr = a; i_flush = fl; i_rst = rs;
    if (fl || rs)
      while (exp_q.size() > 0 && exp_q[$].tag > cyc) begin
        void'(exp_q.pop_back());
        n_drop++;
      end
    if (v && !fl && !rs) begin
      exp_q.push_back('{cyc + LAT, d, a, hsv[23:16], hsv[15:8], hsv[7:0]});
      n_push++;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    put(1'b0, 16'($urandom), AW'($urandom), 1'b0, 1'b0, 24'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * LAT && exp_q.size() > 0; i++) idle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_hsv"}, {o_hue, o_sat, o_val}, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_addr"}, o_addr, 0);
  endtask

  logic [15:0] px;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_data = '0; i_addr = '0;
    @(posedge i_clk); #1;
    for (int i = 0; i < 3; i++) put(1'b0, 16'h0, '0, 1'b0, 1'b1, 24'd0);
    check_zero_outputs("reset");

    // Primaries, back to back.
    put(1'b1, 16'hF800, 18'd0, 1'b0, 1'b0, {8'd0,   8'd255, 8'd255});
    put(1'b1, 16'h07E0, 18'd1, 1'b0, 1'b0, {8'd60,  8'd255, 8'd255});
    put(1'b1, 16'h001F, 18'd2, 1'b0, 1'b0, {8'd120, 8'd255, 8'd255});
    drain();
    for (int i = 0; i < 3; i++) idle();
    check("hold_valid", o_valid, 0);
    check("hold_hue", o_hue, last_e.h);
    check("hold_addr", o_addr, last_e.a);

    // Greys, ties and the hue wrap.
    put(1'b1, 16'hFFFF, 18'd3, 1'b0, 1'b0, {8'd0,   8'd0,   8'd255});
    put(1'b1, 16'h0000, 18'd4, 1'b0, 1'b0, {8'd0,   8'd0,   8'd0});
    idle();
    put(1'b1, 16'hFFE0, 18'd5, 1'b0, 1'b0, {8'd30,  8'd255, 8'd255});
    put(1'b1, 16'hF81F, 18'd6, 1'b0, 1'b0, {8'd150, 8'd255, 8'd255});
    put(1'b1, 16'hF801, 18'd7, 1'b0, 1'b0, {8'd0,   8'd255, 8'd255});
    drain();

    // Random regression with random gaps in i_valid.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) idle();
      px = 16'($urandom);
      put(1'b1, px, AW'(i), 1'b0, 1'b0, hsv_ref(px));
    end
    drain();

    // Flush arrives together with pixel 10; only pixels 11..19 should come out.
    for (int i = 0; i < 20; i++) begin
      px = 16'($urandom);
      put(1'b1, px, AW'(20000 + i), (i == 10), 1'b0, hsv_ref(px));
    end
    drain();

    // Reset with five pixels in flight.
    for (int i = 0; i < 5; i++) begin
      px = 16'($urandom);
      put(1'b1, px, AW'(30000 + i), 1'b0, 1'b0, hsv_ref(px));
    end
    put(1'b0, 16'h0, '0, 1'b0, 1'b1, 24'd0);
    check_zero_outputs("midrst");
    put(1'b0, 16'h0, '0, 1'b0, 1'b1, 24'd0);
    px = 16'h7BEF;
    put(1'b1, px, AW'(31000), 1'b0, 1'b0, hsv_ref(px));
    drain();

    check("out_count", n_out, n_push - n_drop);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
